vcap_regbank: RTL and testbench

VCAP_REGBANK -- requirements
Module: vcap_regbank

---
 rtl/vcap_regbank_if.sv | 26 ++
 rtl/vcap_regbank.sv | 230 +++++++++++++++++++++++
 tb/tb_vcap_regbank.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vcap_regbank_if.sv
// Byte-wide register bus: host (master) writes/reads one byte per cycle of vcap_regbank (slave).
interface vcap_regbank_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] i_addr;
  logic [7:0]        i_data_wr;
  logic              i_select;
  logic              i_wr_req;
  logic [7:0]        o_data_rd;

  modport master (
    output i_addr,
    output i_data_wr,
    output i_select,
    output i_wr_req,
    input  o_data_rd
  );

  modport slave (
    input  i_addr,
    input  i_data_wr,
    input  i_select,
    input  i_wr_req,
    output o_data_rd
  );
endinterface

// File: rtl/vcap_regbank.sv
// Per-channel video capture window/ctrl registers with VSYNC-aligned commit and frame counter.
// Define VCAP_REGBANK_SHADOW_EN for the shadow set + deferred commit; otherwise writes hit the active set directly.
module vcap_regbank #(
  parameter int COORD_W = 12,
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = $clog2(NUM_CH) + 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  vcap_regbank_if.slave             bus,
  input  logic [NUM_CH-1:0]         i_vsync,
  output logic [NUM_CH*COORD_W-1:0] o_x_start,
  output logic [NUM_CH*COORD_W-1:0] o_x_size,
  output logic [NUM_CH*COORD_W-1:0] o_y_start,
  output logic [NUM_CH*COORD_W-1:0] o_y_size,
  output logic [NUM_CH-1:0]         o_HS_inv,
  output logic [NUM_CH-1:0]         o_VS_inv,
  output logic [3*NUM_CH-1:0]       o_mux_mode,
  output logic [NUM_CH-1:0]         o_commit_pending
);

  localparam int                 CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [COORD_W-1:0] SIZE_RST = COORD_W'(256);

  // Byte access helpers; bits at or above COORD_W are dropped on write and read back as 0.
  function automatic logic [COORD_W-1:0] put_lo(input logic [COORD_W-1:0] cur, input logic [7:0] d);
    return {cur[COORD_W-1:8], d};
  endfunction

  function automatic logic [COORD_W-1:0] put_hi(input logic [COORD_W-1:0] cur, input logic [7:0] d);
    return {d[COORD_W-9:0], cur[7:0]};
  endfunction

  function automatic logic [7:0] get_lo(input logic [COORD_W-1:0] v);
    return v[7:0];
  endfunction

  function automatic logic [7:0] get_hi(input logic [COORD_W-1:0] v);
    return 8'(v[COORD_W-1:8]);
  endfunction

  logic [CH_W-1:0] ch;
  logic [3:0]      off;
  logic            wr_en;

  if (NUM_CH > 1) begin : g_ch_dec
    assign ch = bus.i_addr[ADDR_W-1:4];
  end else begin : g_ch_one
    assign ch = '0;
  end

  assign off   = bus.i_addr[3:0];
  assign wr_en = bus.i_select & bus.i_wr_req;

  // Bus-programmed set: the shadow set when shadowing is enabled, otherwise the active set itself.
  logic [COORD_W-1:0] cfg_xs  [NUM_CH];
  logic [COORD_W-1:0] cfg_xw  [NUM_CH];
  logic [COORD_W-1:0] cfg_ys  [NUM_CH];
  logic [COORD_W-1:0] cfg_yh  [NUM_CH];
  logic [2:0]         cfg_mux [NUM_CH];
  logic [NUM_CH-1:0]  cfg_hs;
  logic [NUM_CH-1:0]  cfg_vs;

  logic [COORD_W-1:0] act_xs  [NUM_CH];
  logic [COORD_W-1:0] act_xw  [NUM_CH];
  logic [COORD_W-1:0] act_ys  [NUM_CH];
  logic [COORD_W-1:0] act_yh  [NUM_CH];
  logic [2:0]         act_mux [NUM_CH];
  logic [NUM_CH-1:0]  act_hs;
  logic [NUM_CH-1:0]  act_vs;

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  prev_lvl;
  logic [NUM_CH-1:0]  sync_lvl;
  logic [NUM_CH-1:0]  sync_edge;
  logic [7:0]         frame_cnt [NUM_CH];
  logic [7:0]         rd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cfg_hs <= '0;
      cfg_vs <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cfg_xs[n]  <= '0;
        cfg_xw[n]  <= SIZE_RST;
        cfg_ys[n]  <= '0;
        cfg_yh[n]  <= SIZE_RST;
        cfg_mux[n] <= '0;
      end
    end else if (wr_en) begin
      case (off)
        4'd0: cfg_xs[ch] <= put_lo(cfg_xs[ch], bus.i_data_wr);
        4'd1: cfg_xs[ch] <= put_hi(cfg_xs[ch], bus.i_data_wr);
        4'd2: cfg_xw[ch] <= put_lo(cfg_xw[ch], bus.i_data_wr);
        4'd3: cfg_xw[ch] <= put_hi(cfg_xw[ch], bus.i_data_wr);
        4'd4: cfg_ys[ch] <= put_lo(cfg_ys[ch], bus.i_data_wr);
        4'd5: cfg_ys[ch] <= put_hi(cfg_ys[ch], bus.i_data_wr);
        4'd6: cfg_yh[ch] <= put_lo(cfg_yh[ch], bus.i_data_wr);
        4'd7: cfg_yh[ch] <= put_hi(cfg_yh[ch], bus.i_data_wr);
        4'd8: begin
          cfg_hs[ch]  <= bus.i_data_wr[0];
          cfg_vs[ch]  <= bus.i_data_wr[1];
          cfg_mux[ch] <= bus.i_data_wr[4:2];
        end
        default: ;
      endcase
    end
  end

`ifdef VCAP_REGBANK_SHADOW_EN
  logic [NUM_CH-1:0] cmd_wr;
  logic [NUM_CH-1:0] commit_now;
  logic [NUM_CH-1:0] commit_set;
  logic [NUM_CH-1:0] copy;

  // A deferred-commit write that lands on a sync edge must not copy; it arms the next edge instead.
  always_comb begin
    cmd_wr = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      cmd_wr[n] = wr_en && (off == 4'd9) && (ch == CH_W'(n));
    end
    commit_now = cmd_wr & {NUM_CH{bus.i_data_wr[1]}};
    commit_set = cmd_wr & {NUM_CH{bus.i_data_wr[0] & ~bus.i_data_wr[1]}};
    copy       = commit_now | (sync_edge & pending & ~commit_set);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pending <= '0;
      act_hs  <= '0;
      act_vs  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        act_xs[n]  <= '0;
        act_xw[n]  <= SIZE_RST;
        act_ys[n]  <= '0;
        act_yh[n]  <= SIZE_RST;
        act_mux[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (copy[n]) begin
          act_xs[n]  <= cfg_xs[n];
          act_xw[n]  <= cfg_xw[n];
          act_ys[n]  <= cfg_ys[n];
          act_yh[n]  <= cfg_yh[n];
          act_mux[n] <= cfg_mux[n];
          act_hs[n]  <= cfg_hs[n];
          act_vs[n]  <= cfg_vs[n];
        end
        if (commit_now[n]) begin
          pending[n] <= 1'b0;
        end else if (commit_set[n]) begin
          pending[n] <= 1'b1;
        end else if (copy[n]) begin
          pending[n] <= 1'b0;
        end
      end
    end
  end
`else
  assign act_xs  = cfg_xs;
  assign act_xw  = cfg_xw;
  assign act_ys  = cfg_ys;
  assign act_yh  = cfg_yh;
  assign act_mux = cfg_mux;
  assign act_hs  = cfg_hs;
  assign act_vs  = cfg_vs;
  assign pending = '0;
`endif

  // prev_lvl resets high so a VSYNC already asserted at reset release is not taken as an edge.
  assign sync_lvl  = i_vsync ^ act_vs;
  assign sync_edge = sync_lvl & ~prev_lvl;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_lvl <= '1;
      for (int n = 0; n < NUM_CH; n++) begin
        frame_cnt[n] <= '0;
      end
    end else begin
      prev_lvl <= sync_lvl;
      for (int n = 0; n < NUM_CH; n++) begin
        if (sync_edge[n]) begin
          frame_cnt[n] <= frame_cnt[n] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      4'd0:    rd = get_lo(cfg_xs[ch]);
      4'd1:    rd = get_hi(cfg_xs[ch]);
      4'd2:    rd = get_lo(cfg_xw[ch]);
      4'd3:    rd = get_hi(cfg_xw[ch]);
      4'd4:    rd = get_lo(cfg_ys[ch]);
      4'd5:    rd = get_hi(cfg_ys[ch]);
      4'd6:    rd = get_lo(cfg_yh[ch]);
      4'd7:    rd = get_hi(cfg_yh[ch]);
      4'd8:    rd = {3'b000, cfg_mux[ch], cfg_vs[ch], cfg_hs[ch]};
      4'd9:    rd = {7'd0, pending[ch]};
      4'd10:   rd = frame_cnt[ch];
      default: rd = '0;
    endcase
  end

  assign bus.o_data_rd = rd;

  always_comb begin
    o_x_start  = '0;
    o_x_size   = '0;
    o_y_start  = '0;
    o_y_size   = '0;
    o_mux_mode = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      o_x_start[n*COORD_W +: COORD_W] = act_xs[n];
      o_x_size[n*COORD_W +: COORD_W]  = act_xw[n];
      o_y_start[n*COORD_W +: COORD_W] = act_ys[n];
      o_y_size[n*COORD_W +: COORD_W]  = act_yh[n];
      o_mux_mode[3*n +: 3]            = act_mux[n];
    end
  end

  assign o_HS_inv         = act_hs;
  assign o_VS_inv         = act_vs;
  assign o_commit_pending = pending;

endmodule

// File: tb/tb_vcap_regbank.sv
// Self-checking bench for vcap_regbank; expectations come from a field-level model of the register rules.
`timescale 1ns/1ps
module tb_vcap_regbank;

  localparam int CW = 12;
  localparam int NC = 2;
  localparam int AW = 5;
`ifdef VCAP_REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam int F_XS = 0, F_XW = 1, F_YS = 2, F_YH = 3, F_HS = 4, F_VS = 5, F_MUX = 6;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic [NC-1:0]     vsync = '0;
  logic [NC*CW-1:0]  x_start, x_size, y_start, y_size;
  logic [NC-1:0]     hs_inv, vs_inv, commit_pending;
  logic [3*NC-1:0]   mux_mode;

  int checks = 0;
  int errors = 0;

  vcap_regbank_if #(.ADDR_W(AW)) bus ();

  vcap_regbank #(.COORD_W(CW), .NUM_CH(NC)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .bus              (bus),
    .i_vsync          (vsync),
    .o_x_start        (x_start),
    .o_x_size         (x_size),
    .o_y_start        (y_start),
    .o_y_size         (y_size),
    .o_HS_inv         (hs_inv),
    .o_VS_inv         (vs_inv),
    .o_mux_mode       (mux_mode),
    .o_commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  // Reference model: one integer per register field per channel.
  int m_sh   [NC][7];
  int m_act  [NC][7];
  int m_pend [NC];
  int m_fc   [NC];
  int m_prev [NC];

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int f = 0; f < 7; f++) m_sh[c][f] = 0;
      m_sh[c][F_XW] = 256;
      m_sh[c][F_YH] = 256;
      m_act[c] = m_sh[c];
      m_pend[c] = 0;
      m_fc[c]   = 0;
      m_prev[c] = 1;
    end
  endfunction

  function automatic void model_step();
    int a, d, off, lvl, f;
    bit we, hit, edg;
    we  = (bus.i_select === 1'b1) && (bus.i_wr_req === 1'b1);
    a   = int'(bus.i_addr);
    d   = int'(bus.i_data_wr);
    off = a % 16;
    for (int c = 0; c < NC; c++) begin
      lvl = int'(vsync[c]) ^ m_act[c][F_VS];
      edg = (lvl == 1) && (m_prev[c] == 0);
      hit = we && (a / 16 == c);
      if (SHADOW && hit && off == 9 && (d & 2) != 0) begin
        m_act[c] = m_sh[c];
        m_pend[c] = 0;
      end else if (SHADOW && hit && off == 9 && (d & 1) != 0) begin
        m_pend[c] = 1;
      end else if (edg && m_pend[c] == 1) begin
        m_act[c] = m_sh[c];
        m_pend[c] = 0;
      end
      if (hit && off <= 7) begin
        f = off / 2;
        if (off % 2 == 1) m_sh[c][f] = m_sh[c][f] % 256 + (d * 256) % (1 << CW);
        else              m_sh[c][f] = m_sh[c][f] - m_sh[c][f] % 256 + d;
      end else if (hit && off == 8) begin
        m_sh[c][F_HS]  = d % 2;
        m_sh[c][F_VS]  = (d / 2) % 2;
        m_sh[c][F_MUX] = (d / 4) % 8;
      end
      if (!SHADOW) m_act[c] = m_sh[c];
      if (edg) m_fc[c] = (m_fc[c] + 1) % 256;
      m_prev[c] = lvl;
    end
  endfunction

  function automatic logic [NC*CW-1:0] exp_coord(int f);
    logic [NC*CW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*CW +: CW] = CW'(m_act[c][f]);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_bit(int f);
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = (m_act[c][f] != 0);
    return r;
  endfunction

  function automatic logic [3*NC-1:0] exp_mux();
    logic [3*NC-1:0] r;
    for (int c = 0; c < NC; c++) r[3*c +: 3] = 3'(m_act[c][F_MUX]);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_pend();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = (m_pend[c] != 0);
    return r;
  endfunction

  function automatic logic [7:0] exp_rd(int a);
    int c, off;
    c = a / 16;
    off = a % 16;
    if (off <= 7)  return 8'((m_sh[c][off / 2] >> (8 * (off % 2))) % 256);
    if (off == 8)  return 8'(m_sh[c][F_HS] + 2 * m_sh[c][F_VS] + 4 * m_sh[c][F_MUX]);
    if (off == 9)  return 8'(m_pend[c]);
    if (off == 10) return 8'(m_fc[c]);
    return 8'd0;
  endfunction

  task automatic tick();
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(int a, int d);
    bus.i_select  = 1'b1;
    bus.i_wr_req  = 1'b1;
    bus.i_addr    = AW'(a);
    bus.i_data_wr = 8'(d);
    tick();
    bus.i_wr_req  = 1'b0;
    bus.i_select  = 1'b0;
  endtask

  task automatic set_addr(int a);
    bus.i_addr = AW'(a);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (x_size !== {NC{12'd256}}) begin errors++; $display("FAIL reset_x_size got=%h exp=%h", x_size, {NC{12'd256}}); end
    checks++;
    if (x_start !== '0 || y_start !== '0) begin errors++; $display("FAIL reset_start got=%h/%h exp=0", x_start, y_start); end
    checks++;
    if ({hs_inv, vs_inv, mux_mode, commit_pending} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%h exp=0", {hs_inv, vs_inv, mux_mode, commit_pending});
    end
    checks++;
    if (y_size !== exp_coord(F_YH)) begin errors++; $display("FAIL reset_y_size got=%h exp=%h", y_size, exp_coord(F_YH)); end
    for (int c = 0; c < NC; c++) begin
      set_addr(c * 16 + 3);
      checks++;
      if (bus.o_data_rd !== 8'h01) begin errors++; $display("FAIL reset_rd_xsize_hi ch%0d got=%h exp=01", c, bus.o_data_rd); end
    end
  endtask

  task automatic test_deferred_commit();
    vsync = '0;
    tick();
    tick();
    bus_write(16 + 0, 'h34);
    bus_write(16 + 1, 'h02);
    bus_write(16 + 9, 'h01);
    checks++;
    if (x_start !== exp_coord(F_XS)) begin errors++; $display("FAIL deferred_before got=%h exp=%h", x_start, exp_coord(F_XS)); end
    checks++;
    if (commit_pending !== exp_pend()) begin errors++; $display("FAIL deferred_pending got=%b exp=%b", commit_pending, exp_pend()); end
    repeat (3) begin
      tick();
      checks++;
      if (x_start !== exp_coord(F_XS)) begin errors++; $display("FAIL deferred_hold got=%h exp=%h", x_start, exp_coord(F_XS)); end
    end
    vsync[1] = 1'b1;
    tick();
    checks++;
    if (x_start[CW +: CW] !== 12'h234) begin errors++; $display("FAIL deferred_edge got=%h exp=234", x_start[CW +: CW]); end
    checks++;
    if (x_start[CW-1:0] !== 12'h000) begin errors++; $display("FAIL deferred_ch0 got=%h exp=000", x_start[CW-1:0]); end
    checks++;
    if (commit_pending !== '0) begin errors++; $display("FAIL deferred_cleared got=%b exp=0", commit_pending); end
    vsync[1] = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    vsync[0] = 1'b0;
    tick();
    bus_write(2, 'h80);
    vsync[0] = 1'b1;
    bus_write(9, 'h01);
    checks++;
    if (x_size !== exp_coord(F_XW)) begin errors++; $display("FAIL collide_no_copy got=%h exp=%h", x_size, exp_coord(F_XW)); end
    checks++;
    if (commit_pending !== exp_pend()) begin errors++; $display("FAIL collide_pending got=%b exp=%b", commit_pending, exp_pend()); end
    set_addr(9);
    checks++;
    if (bus.o_data_rd !== exp_rd(9)) begin errors++; $display("FAIL collide_rd_status got=%h exp=%h", bus.o_data_rd, exp_rd(9)); end
    vsync[0] = 1'b0;
    tick();
    checks++;
    if (x_size !== exp_coord(F_XW)) begin errors++; $display("FAIL collide_hold got=%h exp=%h", x_size, exp_coord(F_XW)); end
    // next edge copies, and a shadow write in that same cycle must not be part of the copy
    vsync[0] = 1'b1;
    bus_write(0, 'h11);
    checks++;
    if ({x_size, x_start} !== {exp_coord(F_XW), exp_coord(F_XS)}) begin
      errors++; $display("FAIL collide_copy got=%h exp=%h", {x_size, x_start}, {exp_coord(F_XW), exp_coord(F_XS)});
    end
    checks++;
    if (x_size[CW-1:0] !== 12'h180) begin errors++; $display("FAIL collide_copy_size got=%h exp=180", x_size[CW-1:0]); end
    set_addr(0);
    checks++;
    if (bus.o_data_rd !== 8'h11) begin errors++; $display("FAIL collide_rd_shadow got=%h exp=11", bus.o_data_rd); end
  endtask

  task automatic test_immediate_inv();
    int fc0;
    bus_write(8, 'h02);
    checks++;
    if (vs_inv !== exp_bit(F_VS)) begin errors++; $display("FAIL inv_before_commit got=%b exp=%b", vs_inv, exp_bit(F_VS)); end
    bus_write(9, 'h02);
    checks++;
    if (vs_inv[0] !== 1'b1) begin errors++; $display("FAIL inv_immediate got=%b exp=1", vs_inv[0]); end
    checks++;
    if ({commit_pending, x_start} !== {exp_pend(), exp_coord(F_XS)}) begin
      errors++; $display("FAIL inv_commit_state got=%h exp=%h", {commit_pending, x_start}, {exp_pend(), exp_coord(F_XS)});
    end
    tick();
    fc0 = m_fc[0];
    vsync[0] = 1'b0;
    tick();
    set_addr(10);
    checks++;
    if (bus.o_data_rd !== 8'(fc0 + 1)) begin errors++; $display("FAIL inv_fall_edge got=%h exp=%h", bus.o_data_rd, 8'(fc0 + 1)); end
  endtask

  task automatic test_width_wrap();
    int start;
    bus_write(1, 'hFF);
    set_addr(1);
    checks++;
    if (bus.o_data_rd !== 8'h0F) begin errors++; $display("FAIL width_hi_mask got=%h exp=0F", bus.o_data_rd); end
    bus_write(16 + 8, 'hFC);
    set_addr(16 + 8);
    checks++;
    if (bus.o_data_rd !== 8'h1C) begin errors++; $display("FAIL ctrl_mask got=%h exp=1C", bus.o_data_rd); end
    for (int off = 11; off < 16; off++) begin
      bus_write(16 + off, 'hA5);
      set_addr(16 + off);
      checks++;
      if (bus.o_data_rd !== 8'h00) begin errors++; $display("FAIL reserved_%0d got=%h exp=00", off, bus.o_data_rd); end
    end
    start = m_fc[1];
    repeat (256) begin
      vsync[1] = 1'b1;
      tick();
      vsync[1] = 1'b0;
      tick();
    end
    set_addr(16 + 10);
    checks++;
    if (bus.o_data_rd !== 8'(start)) begin errors++; $display("FAIL frame_wrap got=%h exp=%h", bus.o_data_rd, 8'(start)); end
  endtask

  task automatic test_random(int n);
    int ra;
    for (int i = 0; i < n; i++) begin
      bus.i_select  = 1'($urandom_range(0, 1));
      bus.i_wr_req  = 1'($urandom_range(0, 1));
      bus.i_addr    = AW'($urandom_range(0, 31));
      bus.i_data_wr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) vsync = vsync ^ NC'(1 << $urandom_range(0, NC - 1));
      tick();
      checks++;
      if ({x_start, x_size, y_start, y_size} !== {exp_coord(F_XS), exp_coord(F_XW), exp_coord(F_YS), exp_coord(F_YH)}) begin
        errors++;
        $display("FAIL rand_coords cycle %0d got=%h exp=%h", i, {x_start, x_size, y_start, y_size},
                 {exp_coord(F_XS), exp_coord(F_XW), exp_coord(F_YS), exp_coord(F_YH)});
      end
      checks++;
      if ({hs_inv, vs_inv, mux_mode, commit_pending} !== {exp_bit(F_HS), exp_bit(F_VS), exp_mux(), exp_pend()}) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d got=%h exp=%h", i, {hs_inv, vs_inv, mux_mode, commit_pending},
                 {exp_bit(F_HS), exp_bit(F_VS), exp_mux(), exp_pend()});
      end
      bus.i_wr_req = 1'b0;
      ra = $urandom_range(0, 31);
      set_addr(ra);
      checks++;
      if (bus.o_data_rd !== exp_rd(ra)) begin
        errors++; $display("FAIL rand_rd addr %0d got=%h exp=%h", ra, bus.o_data_rd, exp_rd(ra));
      end
    end
    bus.i_select = 1'b0;
    bus.i_wr_req = 1'b0;
  endtask

  task automatic test_reset_midframe();
    vsync = '1;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (x_size !== {NC{12'd256}}) begin errors++; $display("FAIL mid_reset_x_size got=%h exp=%h", x_size, {NC{12'd256}}); end
    checks++;
    if (x_start !== '0) begin errors++; $display("FAIL mid_reset_x_start got=%h exp=0", x_start); end
    checks++;
    if (commit_pending !== '0) begin errors++; $display("FAIL mid_reset_pending got=%b exp=0", commit_pending); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      set_addr(c * 16 + 10);
      checks++;
      if (bus.o_data_rd !== 8'h00) begin errors++; $display("FAIL mid_reset_fc ch%0d got=%h exp=00", c, bus.o_data_rd); end
    end
    tick();
    set_addr(10);
    checks++;
    if (bus.o_data_rd !== 8'h00) begin errors++; $display("FAIL release_high_vsync got=%h exp=00", bus.o_data_rd); end
  endtask

  initial begin
    bus.i_addr    = '0;
    bus.i_data_wr = '0;
    bus.i_select  = 1'b0;
    bus.i_wr_req  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_deferred_commit();
    test_collision();
    test_immediate_inv();
    test_width_wrap();
    test_random(1500);
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
